fetch_unit: RTL and testbench

- Single-clock instruction fetch stage directly upstream of the memory unit.
- Owns the program counter and drives the instruction address and BIOS-select into the memory unit.
- Receives the 16-bit instruction the memory unit returns one cycle later and presents it to decode with its PC and a valid flag.
- Handles boot hand-off from BIOS to main memory, branch redirects, decode stalls and halt.

---
 rtl/fetch_unit_pkg.sv | 13 +
 rtl/fetch_skid_buffer.sv | 35 +++
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        BIOS_RUN = 2'd0,
        MAIN_RUN = 2'd1,
        HALTED   = 2'd2
    } fetch_state_t;

    localparam int unsigned FETCH_BIOS_START = 0;
    localparam int unsigned FETCH_INSTR_SIZE = 16;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid register that parks the in-flight instruction during a stall.
module fetch_skid_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int INSTRUCTION_SIZE = FETCH_INSTR_SIZE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic                        drain,
    input  logic                        flush,
    input  logic [INSTRUCTION_SIZE-1:0] instr,
    input  logic [DATA_WIDTH-1:0]       pc,
    input  logic                        valid,
    output logic [INSTRUCTION_SIZE-1:0] skid_instr,
    output logic [DATA_WIDTH-1:0]       skid_pc,
    output logic                        skid_valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_instr <= '0;
            skid_pc    <= '0;
            skid_valid <= 1'b0;
        end else if (flush || drain) begin
            skid_valid <= 1'b0;
        end else if (load) begin
            skid_instr <= instr;
            skid_pc    <= pc;
            skid_valid <= valid;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, BIOS hand-off, redirects, stall and halt.
// Define FETCH_SKID_EN for a zero-bubble skid buffer instead of replay.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DATA_WIDTH       = 32,
    parameter int          INSTRUCTION_SIZE = FETCH_INSTR_SIZE,
    parameter int unsigned BIOS_START       = FETCH_BIOS_START
) (
    input  logic                        slow_clock,
    input  logic                        reset,
    input  logic                        halt,
    input  logic                        boot_done,
    input  logic                        branch_taken,
    input  logic [DATA_WIDTH-1:0]       branch_target,
    input  logic                        stall,
    input  logic [INSTRUCTION_SIZE-1:0] instruction_in,
    output logic [DATA_WIDTH-1:0]       instruction_address,
    output logic                        is_bios,
    output logic [INSTRUCTION_SIZE-1:0] instruction_out,
    output logic [DATA_WIDTH-1:0]       instruction_pc,
    output logic                        instruction_valid
);

    localparam logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(BIOS_START);
    localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(1);

    fetch_state_t                state;
    fetch_state_t                state_next;
    logic [DATA_WIDTH-1:0]       fetch_pc;
    logic [DATA_WIDTH-1:0]       fetch_pc_next;
    logic                        is_bios_next;
    logic [DATA_WIDTH-1:0]       inflight_pc;
    logic [DATA_WIDTH-1:0]       inflight_pc_next;
    logic                        inflight_valid;
    logic                        inflight_valid_next;
    logic [INSTRUCTION_SIZE-1:0] out_next;
    logic [DATA_WIDTH-1:0]       out_pc_next;
    logic                        out_valid_next;

`ifdef FETCH_SKID_EN
    logic                        skid_load;
    logic                        skid_drain;
    logic                        skid_flush;
    logic [INSTRUCTION_SIZE-1:0] skid_instr;
    logic [DATA_WIDTH-1:0]       skid_pc;
    logic                        skid_valid;

    fetch_skid_buffer #(
        .DATA_WIDTH       (DATA_WIDTH),
        .INSTRUCTION_SIZE (INSTRUCTION_SIZE)
    ) u_skid (
        .clk        (slow_clock),
        .reset      (reset),
        .load       (skid_load),
        .drain      (skid_drain),
        .flush      (skid_flush),
        .instr      (instruction_in),
        .pc         (inflight_pc),
        .valid      (inflight_valid),
        .skid_instr (skid_instr),
        .skid_pc    (skid_pc),
        .skid_valid (skid_valid)
    );
`endif

    assign instruction_address = fetch_pc;

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            state             <= BIOS_RUN;
            fetch_pc          <= RESET_PC;
            is_bios           <= 1'b1;
            inflight_pc       <= '0;
            inflight_valid    <= 1'b0;
            instruction_out   <= '0;
            instruction_pc    <= '0;
            instruction_valid <= 1'b0;
        end else begin
            state             <= state_next;
            fetch_pc          <= fetch_pc_next;
            is_bios           <= is_bios_next;
            inflight_pc       <= inflight_pc_next;
            inflight_valid    <= inflight_valid_next;
            instruction_out   <= out_next;
            instruction_pc    <= out_pc_next;
            instruction_valid <= out_valid_next;
        end
    end

    always_comb begin
        state_next          = state;
        fetch_pc_next       = fetch_pc;
        is_bios_next        = is_bios;
        inflight_pc_next    = inflight_pc;
        inflight_valid_next = inflight_valid;
        out_next            = instruction_out;
        out_pc_next         = instruction_pc;
        out_valid_next      = instruction_valid;
`ifdef FETCH_SKID_EN
        skid_load           = 1'b0;
        skid_drain          = 1'b0;
        skid_flush          = 1'b0;
`endif
        if (halt || state == HALTED) begin
            state_next          = HALTED;
            out_valid_next      = 1'b0;
            inflight_valid_next = 1'b0;
`ifdef FETCH_SKID_EN
            skid_flush          = 1'b1;
`endif
        end else if (boot_done && state == BIOS_RUN) begin
            // a branch in the same cycle is dropped with the BIOS stream
            state_next          = MAIN_RUN;
            is_bios_next        = 1'b0;
            fetch_pc_next       = '0;
            out_valid_next      = 1'b0;
            inflight_valid_next = 1'b0;
`ifdef FETCH_SKID_EN
            skid_flush          = 1'b1;
`endif
        end else if (branch_taken) begin
            fetch_pc_next       = branch_target;
            out_valid_next      = 1'b0;
            inflight_valid_next = 1'b0;
`ifdef FETCH_SKID_EN
            skid_flush          = 1'b1;
`endif
        end else if (stall) begin
            inflight_valid_next = 1'b0;
`ifdef FETCH_SKID_EN
            skid_load           = !skid_valid;
`else
            // the returning word is lost, so refetch it
            if (inflight_valid) begin
                fetch_pc_next = inflight_pc;
            end
`endif
        end else begin
            out_next            = instruction_in;
            out_pc_next         = inflight_pc;
            out_valid_next      = inflight_valid;
`ifdef FETCH_SKID_EN
            if (skid_valid) begin
                out_next       = skid_instr;
                out_pc_next    = skid_pc;
                out_valid_next = 1'b1;
                skid_drain     = 1'b1;
            end
`endif
            inflight_pc_next    = fetch_pc;
            inflight_valid_next = 1'b1;
            fetch_pc_next       = fetch_pc + PC_STEP;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: boot, redirects, stall, wrap, halt, reset.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] instr;
    } sb_item_t;

`ifdef FETCH_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        slow_clock = 1'b0;
    logic        reset;
    logic        halt;
    logic        boot_done;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic [15:0] instruction_in = '0;
    logic [31:0] instruction_address;
    logic        is_bios;
    logic [15:0] instruction_out;
    logic [31:0] instruction_pc;
    logic        instruction_valid;

    sb_item_t exp_q[$];
    int       n_checks = 0;
    int       n_fail   = 0;

    fetch_unit dut (
        .slow_clock          (slow_clock),
        .reset               (reset),
        .halt                (halt),
        .boot_done           (boot_done),
        .branch_taken        (branch_taken),
        .branch_target       (branch_target),
        .stall               (stall),
        .instruction_in      (instruction_in),
        .instruction_address (instruction_address),
        .is_bios             (is_bios),
        .instruction_out     (instruction_out),
        .instruction_pc      (instruction_pc),
        .instruction_valid   (instruction_valid)
    );

    always #5 slow_clock = ~slow_clock;

    function automatic logic [15:0] mem_word(input logic [31:0] a,
                                             input logic bios);
        return a[15:0] + (bios ? 16'h1000 : 16'h2000);
    endfunction

    always @(posedge slow_clock)
        instruction_in <= mem_word(instruction_address, is_bios);

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_range(input logic [31:0] start, input int count,
                              input logic bios);
        sb_item_t e;
        for (int i = 0; i < count; i++) begin
            e.pc    = start + 32'(i);
            e.instr = mem_word(e.pc, bios);
            exp_q.push_back(e);
        end
    endtask

    // Called at a negedge with inputs set for the coming edge.
    task automatic cycle();
        sb_item_t e;
        if (instruction_valid && !stall) begin
            check("sb_expect", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("xfer_pc", 64'(instruction_pc), 64'(e.pc));
                check("xfer_instr", 64'(instruction_out), 64'(e.instr));
            end
        end
        @(negedge slow_clock);
    endtask

    task automatic run_until_pc(input logic [31:0] pc);
        int n = 0;
        while (!(instruction_valid && instruction_pc == pc) && n < 40) begin
            cycle();
            n++;
        end
        check("reach_pc", 64'(instruction_valid && instruction_pc == pc), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, 64'(instruction_address), 64'd0);
        check({tag, "_bios"}, 64'(is_bios), 64'd1);
        check({tag, "_valid"}, 64'(instruction_valid), 64'd0);
        check({tag, "_out"}, 64'(instruction_out), 64'd0);
        check({tag, "_pc"}, 64'(instruction_pc), 64'd0);
    endtask

    initial begin
        reset         = 1'b1;
        halt          = 1'b0;
        boot_done     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        stall         = 1'b0;
        repeat (2) @(negedge slow_clock);
        check_reset_outputs("rst");
        reset = 1'b0;

        // BIOS free run; boot hand-off while address 5 is presented
        push_range(32'd0, 4, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            cycle();
            check("bios_addr", 64'(instruction_address), 64'(k));
            check("bios_sel", 64'(is_bios), 64'd1);
            if (k == 1) check("edge1_valid", 64'(instruction_valid), 64'd0);
            if (k == 2) begin
                check("edge2_valid", 64'(instruction_valid), 64'd1);
                check("edge2_pc", 64'(instruction_pc), 64'd0);
                check("edge2_instr", 64'(instruction_out), 64'h1000);
            end
        end
        boot_done = 1'b1;
        cycle();
        boot_done = 1'b0;
        check("boot_bios", 64'(is_bios), 64'd0);
        check("boot_addr", 64'(instruction_address), 64'd0);
        check("boot_inv1", 64'(instruction_valid), 64'd0);
        check("boot_drained", 64'(exp_q.size()), 64'd0);
        push_range(32'd0, 10, 1'b0);
        cycle();
        check("boot_inv2", 64'(instruction_valid), 64'd0);
        cycle();
        check("boot_valid", 64'(instruction_valid), 64'd1);
        check("boot_pc", 64'(instruction_pc), 64'd0);

        // stall for three edges while pc 7 is held
        run_until_pc(32'd7);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_pc", 64'(instruction_pc), 64'd7);
            check("stall_valid", 64'(instruction_valid), 64'd1);
        end
        stall = 1'b0;
        cycle();
        check("release_valid", 64'(instruction_valid), 64'(SKID));
        if (SKID) check("release_pc", 64'(instruction_pc), 64'd8);

        // branch issued together with stall; branch wins
        run_until_pc(32'd10);
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        stall         = 1'b1;
        cycle();
        branch_taken = 1'b0;
        stall        = 1'b0;
        check("br_addr", 64'(instruction_address), 64'h40);
        check("br_inv1", 64'(instruction_valid), 64'd0);
        check("br_drained", 64'(exp_q.size()), 64'd0);
        push_range(32'h40, 3, 1'b0);
        cycle();
        check("br_inv2", 64'(instruction_valid), 64'd0);
        cycle();
        check("br_valid", 64'(instruction_valid), 64'd1);
        check("br_pc", 64'(instruction_pc), 64'h40);

        // address wrap at the top of the space
        run_until_pc(32'h42);
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        cycle();
        branch_taken = 1'b0;
        check("wrap_addr0", 64'(instruction_address), 64'hFFFF_FFFF);
        check("wrap_drained", 64'(exp_q.size()), 64'd0);
        push_range(32'hFFFF_FFFF, 4, 1'b0);
        cycle();
        check("wrap_addr1", 64'(instruction_address), 64'd0);
        cycle();
        check("wrap_addr2", 64'(instruction_address), 64'd1);
        check("wrap_pc", 64'(instruction_pc), 64'hFFFF_FFFF);

        // halt: valid drops and the address freezes until reset
        run_until_pc(32'd2);
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        check("halt_drained", 64'(exp_q.size()), 64'd0);
        for (int k = 0; k < 3; k++) begin
            check("halt_valid", 64'(instruction_valid), 64'd0);
            check("halt_addr", 64'(instruction_address), 64'd4);
            cycle();
        end

        // asynchronous reset between edges
        #2 reset = 1'b1;
        #1 check_reset_outputs("arst");
        @(negedge slow_clock);
        reset = 1'b0;
        push_range(32'd0, 2, 1'b1);
        cycle();
        check("rb_inv", 64'(instruction_valid), 64'd0);
        cycle();
        check("rb_valid", 64'(instruction_valid), 64'd1);
        check("rb_pc", 64'(instruction_pc), 64'd0);
        check("rb_bios", 64'(is_bios), 64'd1);
        cycle();
        cycle();
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
